// File: rtl/interlock_pkg.sv
// Shared constants for the interlock input front end: board I/O counts,
// idle (reset) levels of the raw pins and the two standard debounce depths.
package interlock_pkg;

    localparam int NUM_SW  = 4;
    localparam int NUM_KEY = 3;

    // Raw pin levels when nothing is switched on or pressed.
    localparam logic SW_IDLE  = 1'b0;
    localparam logic KEY_IDLE = 1'b1;

    localparam int DEBOUNCE_CYCLES_SIM   = 4;
    localparam int DEBOUNCE_CYCLES_BOARD = 500000;

endpackage

// File: rtl/interlock_input_conditioner_debounce_cell.sv
// One input bit: SYNC_STAGES-deep synchronizer followed by a counter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce_cell #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic IDLE            = 1'b0
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic stable
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   stable_reg;
    logic                   synced;

    assign synced = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync_reg   <= {SYNC_STAGES{IDLE}};
            count_reg  <= '0;
            stable_reg <= IDLE;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
            // Any sample that agrees with the current level restarts the count.
            if (synced == stable_reg) begin
                count_reg <= '0;
            end else if (count_reg == TERMINAL) begin
                stable_reg <= synced;
                count_reg  <= '0;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign stable = stable_reg;

endmodule

// File: rtl/interlock_input_conditioner.sv
// Conditions raw switches and active-low keys into clean levels and press pulses.
// Optional build macro KEY_AUTOREPEAT_EN adds per-key auto-repeat pulses.
module interlock_input_conditioner
    import interlock_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NUM_SW-1:0]  SW,
    input  logic [NUM_KEY-1:0] KEY,
    output logic [NUM_SW-1:0]  sw_stable,
    output logic [NUM_KEY-1:0] key_held,
    output logic [NUM_KEY-1:0] key_press
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic [NUM_SW-1:0]  sw_clean;
    logic [NUM_KEY-1:0] key_clean;
    logic [NUM_KEY-1:0] key_down;
    logic [NUM_KEY-1:0] key_repeat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
            debounce_cell #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .IDLE           (SW_IDLE)
            ) u_cell (
                .Clock (Clock),
                .Reset (Reset),
                .raw   (SW[gi]),
                .stable(sw_clean[gi])
            );
        end

        for (gi = 0; gi < NUM_KEY; gi++) begin : g_key
            debounce_cell #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .IDLE           (KEY_IDLE)
            ) u_cell (
                .Clock (Clock),
                .Reset (Reset),
                .raw   (KEY[gi]),
                .stable(key_clean[gi])
            );
        end
    endgenerate

    // Keys are debounced in pin polarity; internally "pressed" is 1.
    assign key_down = ~key_clean;

`ifdef KEY_AUTOREPEAT_EN
    localparam int               RPT_W    = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [RPT_W-1:0] RPT_DLY  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_WRAP = RPT_W'(REPEAT_DELAY + REPEAT_PERIOD);

    generate
        for (gi = 0; gi < NUM_KEY; gi++) begin : g_repeat
            logic [RPT_W-1:0] rpt_count_reg;
            logic [RPT_W-1:0] rpt_inc;
            logic             still_held;

            assign rpt_inc    = rpt_count_reg + RPT_W'(1);
            assign still_held = key_held[gi] & key_down[gi];

            // Counts cycles since the press edge; folds back to RPT_DLY so every
            // REPEAT_PERIOD cycles after the first repeat lands on RPT_WRAP again.
            always_ff @(posedge Clock) begin
                if (!Reset || !still_held) begin
                    rpt_count_reg <= '0;
                end else if (rpt_inc == RPT_WRAP) begin
                    rpt_count_reg <= RPT_DLY;
                end else begin
                    rpt_count_reg <= rpt_inc;
                end
            end

            assign key_repeat[gi] = still_held & ((rpt_inc == RPT_DLY) | (rpt_inc == RPT_WRAP));
        end
    endgenerate
`else
    assign key_repeat = '0;
`endif

    // Output stage: every output is a flop, and the press edge is taken
    // against the registered key_held so the pulse coincides with its rise.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sw_stable <= '0;
            key_held  <= '0;
            key_press <= '0;
        end else begin
            sw_stable <= sw_clean;
            key_held  <= key_down;
            key_press <= (key_down & ~key_held) | key_repeat;
        end
    end

endmodule

// File: tb/tb_interlock_input_conditioner.sv
// Bench for interlock_input_conditioner: a window-based reference model checked
// every cycle, plus literal expectations at hand-computed cycles.
module tb_interlock_input_conditioner;

    localparam int MAXC = 4096;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] SW    = 4'h0;
    logic [2:0] KEY   = 3'b111;
    logic [3:0] sw_stable;
    logic [2:0] key_held;
    logic [2:0] key_press;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Per posedge: what the DUT pins saw ({pressed keys, switches}) and reset.
    logic [6:0] samp  [MAXC];
    bit         rst_h [MAXC];

    interlock_input_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (4)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .SW       (SW),
        .KEY      (KEY),
        .sw_stable(sw_stable),
        .key_held (key_held),
        .key_press(key_press)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    // Output level at posedge n: value of the most recent run of four equal
    // samples, ending no later than n-3, that lies wholly after the last reset.
    function automatic bit exp_bit(input int b, input int n);
        int last_rst = 0;
        for (int k = n; k >= 0; k--) begin
            if (rst_h[k]) begin
                last_rst = k;
                break;
            end
        end
        if (last_rst == n) return 1'b0;
        for (int j = n - 3; j - 3 > last_rst; j--) begin
            if (samp[j][b] == samp[j-1][b] && samp[j][b] == samp[j-2][b] &&
                samp[j][b] == samp[j-3][b])
                return samp[j][b];
        end
        return 1'b0;
    endfunction

    // Press pulse at posedge n from how long the key has been held (r=0 on the rise).
    function automatic bit exp_press(input int k, input int n);
        int r = 0;
        if (!exp_bit(4 + k, n)) return 1'b0;
        while (n - r - 1 >= 0 && exp_bit(4 + k, n - r - 1)) r++;
`ifdef KEY_AUTOREPEAT_EN
        return (r == 0) || (r >= 8 && (r - 8) % 4 == 0);
`else
        return r == 0;
`endif
    endfunction

    always @(posedge Clock) begin : compare
        logic [3:0] e_sw;
        logic [2:0] e_held;
        logic [2:0] e_press;
        cyc = cyc + 1;
        if (cyc < MAXC) begin
            samp[cyc]  = {~KEY, SW};
            rst_h[cyc] = !Reset;
            #1;
            for (int b = 0; b < 4; b++) e_sw[b] = exp_bit(b, cyc);
            for (int k = 0; k < 3; k++) begin
                e_held[k]  = exp_bit(4 + k, cyc);
                e_press[k] = exp_press(k, cyc);
            end
            check("model_sw_stable", 32'(sw_stable), 32'(e_sw));
            check("model_key_held", 32'(key_held), 32'(e_held));
            check("model_key_press", 32'(key_press), 32'(e_press));
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge Clock);
            #2;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stimulus
        int t;
        rst_h[0] = 1'b1;
        samp[0]  = 7'h0;

        // Reset held with everything asserted
        Reset = 1'b0; SW = 4'hF; KEY = 3'b000;
        repeat (2) @(posedge Clock);
        #2;
        check("reset_sw", 32'(sw_stable), 32'h0);
        check("reset_held", 32'(key_held), 32'h0);
        check("reset_press", 32'(key_press), 32'h0);
        @(negedge Clock); Reset = 1'b1; t = cyc + 1;
        wait_cyc(t + 5);
        check("rel_sw_early", 32'(sw_stable), 32'h0);
        check("rel_held_early", 32'(key_held), 32'h0);
        wait_cyc(t + 6);
        check("rel_sw", 32'(sw_stable), 32'hF);
        check("rel_held", 32'(key_held), 32'b111);
        check("rel_press", 32'(key_press), 32'b111);
        wait_cyc(t + 7);
        check("rel_press_once", 32'(key_press), 32'h0);
        @(negedge Clock); SW = 4'h0; KEY = 3'b111;
        wait_cyc(cyc + 10);

        // Latency on SW[2], rise then fall
        @(negedge Clock); SW = 4'b0100; t = cyc + 1;
        wait_cyc(t + 5);
        check("lat_rise_early", 32'(sw_stable), 32'h0);
        wait_cyc(t + 6);
        check("lat_rise", 32'(sw_stable), 32'b0100);
        wait_cyc(t + 9);
        @(negedge Clock); SW = 4'b0000;
        wait_cyc(t + 15);
        check("lat_fall_early", 32'(sw_stable), 32'b0100);
        wait_cyc(t + 16);
        check("lat_fall", 32'(sw_stable), 32'h0);
        wait_cyc(cyc + 4);

        // Glitch of 3 cycles rejected, pulse of 4 cycles accepted
        @(negedge Clock); SW = 4'b1000; t = cyc + 1;
        wait_cyc(t + 2);
        @(negedge Clock); SW = 4'b0000;
        wait_cyc(t + 10);
        check("glitch3_sw", 32'(sw_stable), 32'h0);
        @(negedge Clock); SW = 4'b1000; t = cyc + 1;
        wait_cyc(t + 3);
        @(negedge Clock); SW = 4'b0000;
        wait_cyc(t + 5);
        check("glitch4_early", 32'(sw_stable), 32'h0);
        wait_cyc(t + 6);
        check("glitch4_rise", 32'(sw_stable), 32'b1000);
        wait_cyc(t + 10);
        check("glitch4_fall", 32'(sw_stable), 32'h0);
        wait_cyc(cyc + 4);

        // KEY[1] held for 12 cycles
        @(negedge Clock); KEY = 3'b101; t = cyc + 1;
        wait_cyc(t + 5);
        check("key_held_early", 32'(key_held), 32'h0);
        wait_cyc(t + 6);
        check("key_held_rise", 32'(key_held), 32'b010);
        check("key_press_pulse", 32'(key_press), 32'b010);
        wait_cyc(t + 7);
        check("key_press_single", 32'(key_press), 32'h0);
        wait_cyc(t + 11);
        @(negedge Clock); KEY = 3'b111;
        wait_cyc(t + 14);
`ifdef KEY_AUTOREPEAT_EN
        check("key_repeat", 32'(key_press), 32'b010);
`else
        check("key_no_repeat", 32'(key_press), 32'h0);
`endif
        wait_cyc(t + 17);
        check("key_held_last", 32'(key_held), 32'b010);
        wait_cyc(t + 18);
        check("key_released", 32'(key_held), 32'h0);
        check("key_no_release_pulse", 32'(key_press), 32'h0);
        wait_cyc(cyc + 4);

        // Simultaneous switch and key
        @(negedge Clock); SW = 4'b0001; KEY = 3'b011; t = cyc + 1;
        wait_cyc(t + 5);
        check("simul_sw_early", 32'(sw_stable), 32'h0);
        check("simul_held_early", 32'(key_held), 32'h0);
        wait_cyc(t + 6);
        check("simul_sw", 32'(sw_stable), 32'b0001);
        check("simul_held", 32'(key_held), 32'b100);
        check("simul_press", 32'(key_press), 32'b100);
        @(negedge Clock); SW = 4'h0; KEY = 3'b111;
        wait_cyc(cyc + 10);

        // Reset in the middle of a debounce
        @(negedge Clock); SW = 4'b0010; t = cyc + 1;
        wait_cyc(t + 3);
        @(negedge Clock); Reset = 1'b0;
        wait_cyc(t + 4);
        check("midrst_sw_in_reset", 32'(sw_stable), 32'h0);
        @(negedge Clock); Reset = 1'b1;
        wait_cyc(t + 5);
        check("midrst_sw_after", 32'(sw_stable), 32'h0);
        wait_cyc(t + 10);
        check("midrst_sw_early", 32'(sw_stable), 32'h0);
        wait_cyc(t + 11);
        check("midrst_sw_rise", 32'(sw_stable), 32'b0010);
        @(negedge Clock); SW = 4'h0;
        wait_cyc(cyc + 10);

        // Bouncy mixed traffic, checked by the model every cycle
        for (int i = 0; i < 24; i++) begin
            @(negedge Clock);
            SW  = 4'((i * 7) ^ (i >> 1));
            KEY = 3'((i * 5) ^ 3);
            repeat (i % 6) @(negedge Clock);
        end
        @(negedge Clock); SW = 4'h0; KEY = 3'b111;
        wait_cyc(cyc + 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interlock_input_conditioner.md
Name: interlock_input_conditioner

Overview:
- Front-end stage that feeds the interlock controller.
- Takes raw board switches SW[3:0] and active-low pushbuttons KEY[2:0], then synchronizes and debounces each one.
- Delivers clean switch levels, clean key-held levels, and single-cycle key-press pulses.
- The interlock FSM consumes only these outputs, never raw pins.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the synchronizer chain per input; minimum 2.
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized value must differ from the stable value before the stable value is updated; minimum 1. Board builds override to 500000.
- REPEAT_DELAY, 8: cycles a key must be held before the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 4: cycles between auto-repeat pulses. Used only with the optional feature.

Ports:
- Clock  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-low reset (0 = reset), sampled on posedge Clock.
- SW  in  4  raw slide switches, asynchronous.
- KEY  in  3  raw pushbuttons, asynchronous, active-low (0 = pressed).
- sw_stable  out  4  debounced switch levels.
- key_held  out  3  debounced key state, active-high (1 = pressed).
- key_press  out  3  one-cycle pulse on each debounced press.

Behaviour:
- Reset (Reset==0 at posedge):
  - Synchronizer flops load idle values: SW chain 0, KEY chain 1.
  - All debounce counters 0.
  - sw_stable=0, key_held=0, key_press=0.
  - Reset overrides all activity, including an in-progress debounce.
- Synchronizer: each of the 7 inputs passes through a SYNC_STAGES-deep flop chain. KEY is inverted after the chain, so internal "pressed" is 1.
- Debounce, per bit, independent:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If synced==stable: counter<=0.
  - Else if counter==DEBOUNCE_CYCLES-1: stable<=synced, counter<=0.
  - Else: counter<=counter+1.
  - Any return to match before terminal count clears the counter. Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Latency: a raw change held steady appears on sw_stable/key_held exactly SYNC_STAGES+DEBOUNCE_CYCLES posedges after the first posedge that samples it. Default: 6.
- key_press[i]:
  - Asserted for exactly one cycle, the cycle key_held[i] rises 0->1.
  - No pulse on release.
  - Default build: a held key never produces a second pulse.
- Simultaneous events:
  - All bits are fully independent.
  - Several key_press bits may pulse in the same cycle.
- Reset mid-operation: counters and stable values are discarded. After Reset returns to 1, an input that is still asserted takes the full latency again.
- No other state. Outputs are registered, with no combinational path from inputs.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - Each key bit has a repeat counter, cleared while key_held[i]==0.
  - After the initial press pulse, if the key is held for REPEAT_DELAY cycles, key_press[i] pulses once.
  - Further pulses follow every REPEAT_PERIOD cycles while the key remains held.
  - Release clears the counter in the same cycle, and no pulse is emitted that cycle.
  - Reset clears the repeat counters.
- Undefined: no repeat counters are synthesized; behaviour is exactly one pulse per press.

Decomposition:
- Shared package interlock_pkg holds:
  - NUM_SW=4 and NUM_KEY=3;
  - SW_IDLE=1'b0 and KEY_IDLE=1'b1 reset values;
  - default DEBOUNCE_CYCLES_SIM=4 and DEBOUNCE_CYCLES_BOARD=500000.
- One sub-module, debounce_cell:
  - parameters SYNC_STAGES, DEBOUNCE_CYCLES, IDLE;
  - ports Clock, Reset, raw, stable.
- The top level instantiates 7 cells and adds edge-detect and repeat logic for the keys.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset: hold Reset=0 for 2 cycles with SW=4'b1111 and KEY=3'b000 -> sw_stable=0, key_held=0, key_press=0 throughout. After release, sw_stable=4'b1111 and key_held=3'b111 six cycles later.
- Latency: SW[2] 0->1 sampled at posedge t and held -> sw_stable[2] rises at posedge t+6, not earlier. SW[2] 1->0 at t+10 -> sw_stable[2] falls at t+16.
- Glitch rejection: SW[3]=1 for 3 cycles, then 0 -> sw_stable[3] stays 0. SW[3]=1 for 4 cycles -> sw_stable[3] rises.
- Key press: KEY[1]=0 for 12 cycles from t -> key_held[1]=1 from t+6 to t+17. key_press[1] is high only at t+6 (exactly one pulse). With KEY_AUTOREPEAT_EN, REPEAT_DELAY=8 and REPEAT_PERIOD=4 -> extra pulses at t+14 only.
- Simultaneous: SW[0]=1 and KEY[2]=0 at the same posedge t -> sw_stable[0] and key_held[2]/key_press[2] all change at t+6, and other bits are unchanged.
- Reset mid-debounce: SW[1]=1 from t, Reset=0 at t+4 for 1 cycle -> sw_stable[1]=0 through t+5. It rises exactly 6 cycles after the first posedge with Reset=1.
